// File: rtl/vout_timing_ctrl.sv
// Video output timing controller: shadow/active parameter sets with frame-boundary
// commit, plus start/stop sequencing of the timing generator enable.
module vout_timing_ctrl #(
  parameter int HFP_WIDTH     = 8,
  parameter int HSW_WIDTH     = 4,
  parameter int HBP_WIDTH     = 8,
  parameter int HACTIVE_WIDTH = 16,
  parameter int VFP_WIDTH     = 8,
  parameter int VSW_WIDTH     = 4,
  parameter int VBP_WIDTH     = 8,
  parameter int VACTIVE_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_wr_en,
  input  logic [3:0]               cfg_addr,
  input  logic [15:0]              cfg_wdata,
  input  logic                     cfg_commit,
  input  logic                     start_req,
  input  logic                     stop_req,
  input  logic                     frame_end_i,
  output logic                     cfg_busy_o,
  output logic                     commit_done_o,
  output logic                     cfg_err_o,
  output logic                     timing_en_o,
  output logic                     hpol_o,
  output logic [HFP_WIDTH-1:0]     hfp_o,
  output logic [HSW_WIDTH-1:0]     hsw_o,
  output logic [HBP_WIDTH-1:0]     hbp_o,
  output logic [HACTIVE_WIDTH-1:0] hactive_o,
  output logic [VFP_WIDTH-1:0]     vfp_o,
  output logic [VSW_WIDTH-1:0]     vsw_o,
  output logic [VBP_WIDTH-1:0]     vbp_o,
  output logic [VACTIVE_WIDTH-1:0] vactive_o,
  output logic [1:0]               state_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]               state_reg, state_next;
  logic                     pend_reg, pend_next;
  logic                     en_reg, en_next;
  logic                     done_reg, err_reg;
  logic                     copy_now, err_next, wr_ok, shadow_valid, frame_edge;

  logic                     sh_hpol_reg;
  logic [HFP_WIDTH-1:0]     sh_hfp_reg;
  logic [HSW_WIDTH-1:0]     sh_hsw_reg;
  logic [HBP_WIDTH-1:0]     sh_hbp_reg;
  logic [HACTIVE_WIDTH-1:0] sh_hactive_reg;
  logic [VFP_WIDTH-1:0]     sh_vfp_reg;
  logic [VSW_WIDTH-1:0]     sh_vsw_reg;
  logic [VBP_WIDTH-1:0]     sh_vbp_reg;
  logic [VACTIVE_WIDTH-1:0] sh_vactive_reg;

  logic                     act_hpol_reg;
  logic [HFP_WIDTH-1:0]     act_hfp_reg;
  logic [HSW_WIDTH-1:0]     act_hsw_reg;
  logic [HBP_WIDTH-1:0]     act_hbp_reg;
  logic [HACTIVE_WIDTH-1:0] act_hactive_reg;
  logic [VFP_WIDTH-1:0]     act_vfp_reg;
  logic [VSW_WIDTH-1:0]     act_vsw_reg;
  logic [VBP_WIDTH-1:0]     act_vbp_reg;
  logic [VACTIVE_WIDTH-1:0] act_vactive_reg;

  always_comb begin
    shadow_valid = (sh_hactive_reg != '0) && (sh_vactive_reg != '0) &&
                   (sh_hsw_reg != '0) && (sh_vsw_reg != '0);
    wr_ok        = cfg_wr_en && !pend_reg && (cfg_addr <= 4'd8);
    frame_edge   = frame_end_i && ((state_reg == ST_RUN) || (state_reg == ST_DRAIN));
    copy_now     = 1'b0;
    err_next     = 1'b0;
    pend_next    = pend_reg;
    state_next   = state_reg;
    en_next      = en_reg;

    case (state_reg)
      ST_IDLE: begin
        en_next = 1'b0;
        // start wins over a coincident commit; both need a valid shadow set
        if (start_req || cfg_commit) begin
          if (shadow_valid) copy_now = 1'b1;
          else              err_next = 1'b1;
        end
        if (start_req && shadow_valid) state_next = ST_ARM;
      end
      ST_ARM: begin
        state_next = ST_RUN;
        en_next    = 1'b1;
      end
      ST_RUN: begin
        if (stop_req) state_next = ST_DRAIN;
      end
      default: begin
        if (frame_end_i) begin
          state_next = ST_IDLE;
          en_next    = 1'b0;
        end
      end
    endcase

    if (state_reg != ST_IDLE && cfg_commit && !pend_reg) begin
      if (!shadow_valid) err_next = 1'b1;
      else if (frame_edge) copy_now = 1'b1;
      else pend_next = 1'b1;
    end
    if (pend_reg && frame_edge) begin
      copy_now  = 1'b1;
      pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      pend_reg        <= 1'b0;
      en_reg          <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      sh_hpol_reg     <= 1'b0;
      sh_hfp_reg      <= '0;
      sh_hsw_reg      <= '0;
      sh_hbp_reg      <= '0;
      sh_hactive_reg  <= '0;
      sh_vfp_reg      <= '0;
      sh_vsw_reg      <= '0;
      sh_vbp_reg      <= '0;
      sh_vactive_reg  <= '0;
      act_hpol_reg    <= 1'b0;
      act_hfp_reg     <= '0;
      act_hsw_reg     <= '0;
      act_hbp_reg     <= '0;
      act_hactive_reg <= '0;
      act_vfp_reg     <= '0;
      act_vsw_reg     <= '0;
      act_vbp_reg     <= '0;
      act_vactive_reg <= '0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      en_reg    <= en_next;
      done_reg  <= copy_now;
      err_reg   <= err_next;
      if (wr_ok) begin
        case (cfg_addr)
          4'd0:    sh_hfp_reg     <= cfg_wdata[HFP_WIDTH-1:0];
          4'd1:    sh_hsw_reg     <= cfg_wdata[HSW_WIDTH-1:0];
          4'd2:    sh_hbp_reg     <= cfg_wdata[HBP_WIDTH-1:0];
          4'd3:    sh_hactive_reg <= cfg_wdata[HACTIVE_WIDTH-1:0];
          4'd4:    sh_vfp_reg     <= cfg_wdata[VFP_WIDTH-1:0];
          4'd5:    sh_vsw_reg     <= cfg_wdata[VSW_WIDTH-1:0];
          4'd6:    sh_vbp_reg     <= cfg_wdata[VBP_WIDTH-1:0];
          4'd7:    sh_vactive_reg <= cfg_wdata[VACTIVE_WIDTH-1:0];
          default: sh_hpol_reg    <= cfg_wdata[0];
        endcase
      end
      // copy uses pre-edge shadow, so a same-cycle write is not part of it
      if (copy_now) begin
        act_hpol_reg    <= sh_hpol_reg;
        act_hfp_reg     <= sh_hfp_reg;
        act_hsw_reg     <= sh_hsw_reg;
        act_hbp_reg     <= sh_hbp_reg;
        act_hactive_reg <= sh_hactive_reg;
        act_vfp_reg     <= sh_vfp_reg;
        act_vsw_reg     <= sh_vsw_reg;
        act_vbp_reg     <= sh_vbp_reg;
        act_vactive_reg <= sh_vactive_reg;
      end
    end
  end

  assign cfg_busy_o    = pend_reg;
  assign commit_done_o = done_reg;
  assign cfg_err_o     = err_reg;
  assign timing_en_o   = en_reg;
  assign state_o       = state_reg;
  assign hpol_o        = act_hpol_reg;
  assign hfp_o         = act_hfp_reg;
  assign hsw_o         = act_hsw_reg;
  assign hbp_o         = act_hbp_reg;
  assign hactive_o     = act_hactive_reg;
  assign vfp_o         = act_vfp_reg;
  assign vsw_o         = act_vsw_reg;
  assign vbp_o         = act_vbp_reg;
  assign vactive_o     = act_vactive_reg;

endmodule
